// File: rtl/ring_osc_trim_cal.sv
// Ring-oscillator trim calibration: counts divided-oscillator edges over a
// reference window and steps a thermometer trim word until the count is in tolerance.
module ring_osc_trim_cal #(
    parameter int WINDOW   = 1024,
    parameter int SETTLE   = 16,
    parameter int MAX_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        osc_div,
    input  logic [15:0] target,
    input  logic [7:0]  tol,
    output logic [25:0] trim,
    output logic [4:0]  level,
    output logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        locked,
    output logic        error
);

    // state      | meaning
    // ST_IDLE    | waiting for start, results held
    // ST_SETTLE  | trim just changed, let the oscillator settle
    // ST_MEASURE | counting osc_div rising edges for WINDOW cycles
    // ST_COMPARE | check count against target +/- tol, adjust level
    // ST_FINISH  | one-cycle done pulse, back to idle

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_COMPARE,
        ST_FINISH
    } state_t;

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int IW   = $clog2(MAX_ITER + 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q;
    logic [IW-1:0]   iter_q;
    logic [15:0]     edge_q, edge_next;
    logic [2:0]      sync_q;
    logic            edge_det;

    logic [16:0]     lo_raw, hi_raw;
    logic [15:0]     lo, hi;
    logic            in_tol, too_fast, too_slow, iter_last;
    logic            step_up, step_down;

    assign edge_det  = sync_q[1] & ~sync_q[2];
    assign edge_next = (edge_det && edge_q != 16'hFFFF) ? edge_q + 16'd1 : edge_q;

    assign lo_raw    = {1'b0, target} - {9'd0, tol};
    assign hi_raw    = {1'b0, target} + {9'd0, tol};
    assign lo        = lo_raw[16] ? 16'd0 : lo_raw[15:0];
    assign hi        = hi_raw[16] ? 16'hFFFF : hi_raw[15:0];
    assign too_fast  = count > hi;
    assign too_slow  = count < lo;
    assign in_tol    = !too_fast && !too_slow;
    assign iter_last = (iter_q == IW'(MAX_ITER - 1));
    assign step_up   = !in_tol && !iter_last && too_fast && (level < 5'd26);
    assign step_down = !in_tol && !iter_last && too_slow && (level > 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_SETTLE;
            ST_SETTLE:  if (tmr_q == '0) state_d = ST_MEASURE;
            ST_MEASURE: if (tmr_q == '0) state_d = ST_COMPARE;
            ST_COMPARE: state_d = (step_up || step_down) ? ST_SETTLE : ST_FINISH;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SETTLE, ST_MEASURE, ST_COMPARE: busy = 1'b1;
            ST_FINISH:                         done = 1'b1;
            default:                           ;
        endcase
    end

    // Thermometer trim: primary bank fills first, then the secondary bank.
    always_comb begin
        trim = '0;
        for (int i = 0; i < 26; i++) trim[i] = (i < int'(level));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 3'b000;
        else       sync_q <= {sync_q[1:0], osc_div};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q  <= '0;
            iter_q <= '0;
            edge_q <= '0;
            level  <= '0;
            count  <= '0;
            locked <= 1'b0;
            error  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        locked <= 1'b0;
                        error  <= 1'b0;
                        iter_q <= '0;
                        tmr_q  <= TW'(SETTLE - 1);
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == '0) begin
                        tmr_q  <= TW'(WINDOW - 1);
                        edge_q <= '0;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                ST_MEASURE: begin
                    edge_q <= edge_next;
                    if (tmr_q == '0) count <= edge_next;
                    else             tmr_q <= tmr_q - TW'(1);
                end
                ST_COMPARE: begin
                    iter_q <= iter_q + IW'(1);
                    if (in_tol) begin
                        locked <= 1'b1;
                    end else if (step_up) begin
                        level <= level + 5'd1;
                        tmr_q <= TW'(SETTLE - 1);
                    end else if (step_down) begin
                        level <= level - 5'd1;
                        tmr_q <= TW'(SETTLE - 1);
                    end else begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_trim_cal.sv
// Bench for ring_osc_trim_cal: behavioural oscillator whose edge rate depends on
// the trim level, with per-run expected results queued and checked at done.
`timescale 1ns/1ps
module tb_ring_osc_trim_cal;

    // Window widened so the oscillator model can reach the requested counts
    // while keeping both phases longer than one reference cycle.
    localparam int WIN    = 2048;
    localparam int STL    = 16;
    localparam int BUDGET = 40000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        osc_div = 1'b0;
    logic [15:0] target;
    logic [7:0]  tol;
    logic [25:0] trim;
    logic [4:0]  level;
    logic [15:0] count;
    logic        busy, done, locked, error;

    typedef struct {
        int level;
        int locked;
        int error;
        int count;
        int slack;
        int trim;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  done_cnt = 0;
    int  osc_mode = 0;
    int  fixed_n  = 600;
    int  osc_n;
    real osc_h;

    ring_osc_trim_cal #(.WINDOW(WIN), .SETTLE(STL), .MAX_ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .osc_div(osc_div),
        .target(target), .tol(tol), .trim(trim), .level(level), .count(count),
        .busy(busy), .done(done), .locked(locked), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp, input int slack);
        int d;
        n_checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > slack) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d) at %0t", tag, obs, exp, slack, $time);
        end
    endtask

    function automatic int model_n();
        case (osc_mode)
            0:       return fixed_n;
            1:       return 800 - 20 * int'(level);
            default: return 0;
        endcase
    endfunction

    // Oscillator plant: mode 3 is exactly clk/4, offset from the clk edges.
    always begin
        if (osc_mode == 3) begin
            @(posedge clk);
            #3;
            while (osc_mode == 3) begin
                osc_div = ~osc_div;
                #20;
            end
        end else begin
            osc_n = model_n();
            if (osc_n <= 0) begin
                #50;
            end else begin
                osc_h = (real'(WIN) * 10.0) / (2.0 * real'(osc_n));
                #(osc_h);
                osc_div = ~osc_div;
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            sb_t e;
            done_cnt++;
            check_val("sb_depth", sb_q.size(), 1, 0);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("level",  int'(level),  e.level,  0);
                check_val("trim",   int'(trim),   e.trim,   0);
                check_val("locked", int'(locked), e.locked, 0);
                check_val("error",  int'(error),  e.error,  0);
                check_val("count",  int'(count),  e.count,  e.slack);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_cal(input int mode, input int fixed, input int tgt, input int tl,
                           input int e_lvl, input int e_lock, input int e_err,
                           input int e_cnt, input int e_slack, input bit poke);
        sb_t e;
        int  d0;
        int  cyc;
        e.level  = e_lvl;
        e.locked = e_lock;
        e.error  = e_err;
        e.count  = e_cnt;
        e.slack  = e_slack;
        e.trim   = (1 << e_lvl) - 1;
        osc_mode = mode;
        fixed_n  = fixed;
        target   = 16'(tgt);
        tol      = 8'(tl);
        d0       = done_cnt;
        sb_q.push_back(e);
        pulse_start();
        check_val("busy_rise", int'(busy), 1, 0);
        cyc = 0;
        while (done_cnt == d0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 300) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                cyc++;
                check_val("busy_hold", int'(busy), 1, 0);
            end
        end
        check_val("done_seen", done_cnt - d0, 1, 0);
        repeat (5) @(negedge clk);
        check_val("done_once", done_cnt - d0, 1, 0);
        check_val("busy_fall", int'(busy), 0, 0);
        if (sb_q.size() > 0) sb_q.delete();
    endtask

    task automatic check_all_zero(input string sfx);
        check_val({"rst_level_", sfx},  int'(level),  0, 0);
        check_val({"rst_trim_", sfx},   int'(trim),   0, 0);
        check_val({"rst_count_", sfx},  int'(count),  0, 0);
        check_val({"rst_busy_", sfx},   int'(busy),   0, 0);
        check_val({"rst_done_", sfx},   int'(done),   0, 0);
        check_val({"rst_locked_", sfx}, int'(locked), 0, 0);
        check_val({"rst_error_", sfx},  int'(error),  0, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset  = 1'b1;
        start  = 1'b0;
        target = 16'd0;
        tol    = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("init");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Count already on target at level 0
        run_cal(0, 600, 600, 4, 0, 1, 0, 600, 1, 1'b0);
        // Count 800-20*level walks the level up to 10
        run_cal(1, 0, 600, 5, 10, 1, 0, 600, 1, 1'b0);
        // Always too fast: level climbs from 10 to the top and errors
        run_cal(0, 900, 100, 10, 26, 0, 1, 900, 1, 1'b0);

        // Reset in the middle of MEASURE aborts without done
        d0       = done_cnt;
        osc_mode = 0;
        fixed_n  = 600;
        target   = 16'd600;
        tol      = 8'd4;
        pulse_start();
        repeat (STL + 200) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_val("no_done_abort", done_cnt - d0, 0, 0);

        // Normal run right after reset release, from level 0
        run_cal(0, 600, 600, 4, 0, 1, 0, 600, 1, 1'b0);
        // Too slow at the bottom bound: error on first compare
        run_cal(0, 50, 600, 4, 0, 0, 1, 50, 1, 1'b0);
        // Exactly clk/4 with a stray start while busy
        run_cal(3, 0, WIN / 4, 2, 0, 1, 0, WIN / 4, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ring_osc_trim_cal.md
RING_OSC_TRIM_CAL -- requirements
Module: ring_osc_trim_cal

Interface
REQ-001 Parameter WINDOW, default 1024: reference clk cycles per measurement window.
REQ-002 Parameter SETTLE, default 16: clk cycles waited after any trim change before measuring.
REQ-003 Parameter MAX_ITER, default 32: maximum measure/adjust iterations per calibration run.
REQ-004 Port clk  input  1: single reference clock; all state is in this domain.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port start  input  1: single-cycle pulse that begins a calibration run when idle.
REQ-007 Port osc_div  input  1: divided ring-oscillator clock, asynchronous to clk, frequency below clk/4.
REQ-008 Port target  input  16: desired osc_div rising-edge count per window.
REQ-009 Port tol  input  8: allowed +/- deviation of the count from target.
REQ-010 Port trim  output  26: oscillator trim word; bits [12:0] are primary, bits [25:13] are secondary.
REQ-011 Port level  output  5: current trim level, 0..26.
REQ-012 Port count  output  16: last completed window count.
REQ-013 Port busy  output  1: high while a run is in progress.
REQ-014 Port done  output  1: one-cycle pulse when a run ends.
REQ-015 Port locked  output  1: run ended within tolerance; held until the next start.
REQ-016 Port error  output  1: run ended without lock; held until the next start.

Function
REQ-017 osc_div shall pass through a 2-flop synchronizer; a rising edge is a 0->1 transition of the second flop, detected with a third flop.
REQ-018 trim shall be a pure function of level.
- L<=13: trim[L-1:0]=1 and all other bits 0.
- L>13: trim[12:0] all 1 and trim[13+(L-13)-1:13]=1.
- L=0 gives all zeros; L=26 gives all ones.
REQ-019 The FSM shall have states IDLE, SETTLE, MEASURE, COMPARE and FINISH.
REQ-020 IDLE: start=1 sets busy=1, clears locked, error and the iteration counter, and enters SETTLE; level is not changed.
REQ-021 SETTLE: waits exactly SETTLE clk cycles, then clears the edge counter and enters MEASURE.
REQ-022 MEASURE: lasts exactly WINDOW clk cycles.
- Each detected edge increments the 16-bit edge counter.
- The edge counter saturates at 0xFFFF.
REQ-023 On MEASURE exit, count shall be updated with the edge counter and the FSM enters COMPARE.
REQ-024 COMPARE arithmetic shall be 17-bit: lo = max(target-tol, 0) and hi = min(target+tol, 0xFFFF).
REQ-025 COMPARE outcomes (the iteration counter increments on every COMPARE visit):
- lo<=count<=hi: set locked, go to FINISH.
- count>hi (too fast) and level<26: increment level, go to SETTLE.
- count<lo (too slow) and level>0: decrement level, go to SETTLE.
- Adjustment needed but level is at its bound (0 or 26): set error, go to FINISH.
- Iteration counter reaches MAX_ITER without lock: set error, go to FINISH.
REQ-026 FINISH: pulse done=1 for one cycle, clear busy, return to IDLE; level is retained.
REQ-027 start shall be ignored while busy=1.
REQ-028 target and tol shall be sampled only in COMPARE.

Reset
REQ-029 reset=1 shall asynchronously force the following, regardless of state:
- FSM to IDLE.
- level=0, trim=0, count=0.
- busy=0, done=0, locked=0, error=0.
- Synchronizer flops, edge counter and iteration counter to 0.
REQ-030 Reset asserted during SETTLE or MEASURE shall abort the run with no done pulse.
REQ-031 The first start after reset release shall begin a normal run from level 0.

Verification
REQ-032 The bench shall cover the following directed scenarios:
- osc_div model gives count=600 at every level, target=600, tol=4, start -> locked=1, error=0, level=0, single done pulse.
- Model count = 800-20*level, target=600, tol=5 -> level steps 0..10, locked=1 at level 10, trim=0x00003FF.
- Model count fixed at 900, target=100 -> level saturates at 26, trim=0x3FFFFFF, error=1, done pulses once.
- Model count fixed at 50, target=600, from level 0 -> error=1 at the first COMPARE, level stays 0.
- Reset pulse mid-MEASURE -> all outputs zero immediately, no done; next start completes normally.
- start pulsed while busy=1 -> ignored; osc_div at exactly clk/4 -> count=WINDOW/4 (256) within +/-1.
